// File: rtl/tile_lane_tracker_if.sv
// Signal bundle between the song sequencer / VGA renderer and tile_lane_tracker.
// The read port is a plain combinational lookup (no valid/ready): rd_valid/rd_y follow rd_lane/rd_idx in the same cycle.
interface tile_lane_tracker_if #(
  parameter int DEPTH = 4,
  parameter int Y_W   = 10
);
  localparam int PTR_W = $clog2(DEPTH);

  logic             frame_tick;
  logic [3:0]       spawn;
  logic [3:0]       kill;
  logic [3:0]       speed;
  logic             screen;
  logic [1:0]       rd_lane;
  logic [PTR_W-1:0] rd_idx;
  logic             rd_valid;
  logic [Y_W-1:0]   rd_y;
  logic [15:0]      score;
  logic [3:0]       misses;
  logic [3:0]       hit_pulse;
  logic             game_over;
  logic             overflow;

  modport master (
    output frame_tick, spawn, kill, speed, screen, rd_lane, rd_idx,
    input  rd_valid, rd_y, score, misses, hit_pulse, game_over, overflow
  );

  modport slave (
    input  frame_tick, spawn, kill, speed, screen, rd_lane, rd_idx,
    output rd_valid, rd_y, score, misses, hit_pulse, game_over, overflow
  );
endinterface

// File: rtl/tile_lane_tracker.sv
// Per-lane falling-tile tracker: spawns, advances, scores hits/misses, serves tile y to the renderer.
// Optional macro WRONG_PRESS_PENALTY_EN: a press that hits nothing costs one miss.
module tile_lane_tracker #(
  parameter int DEPTH    = 4,
  parameter int Y_W      = 10,
  parameter int SCREEN_H = 480,
  parameter int TILE_H   = 120,
  parameter int HIT_LO   = 360,
  parameter int MAX_MISS = 3
) (
  input logic                Clk,
  input logic                Reset,
  tile_lane_tracker_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [Y_W:0]   L_SCREEN_H = (Y_W+1)'(SCREEN_H);
  localparam logic [Y_W:0]   L_TILE_H   = (Y_W+1)'(TILE_H);
  localparam logic [Y_W:0]   L_HIT_LO   = (Y_W+1)'(HIT_LO);
  localparam logic [3:0]     L_MAX_MISS = 4'(MAX_MISS);
  localparam logic [CNT_W-1:0] L_FULL   = CNT_W'(DEPTH);

  logic [Y_W-1:0]   r_buf   [4][DEPTH];
  logic [PTR_W-1:0] r_head  [4];
  logic [CNT_W-1:0] r_count [4];
  logic [3:0]       r_spawn_prev, r_kill_prev, r_hit_pulse;
  logic [15:0]      r_score;
  logic [3:0]       r_misses;
  logic             r_game_over, r_overflow;

  logic             w_active;
  logic [3:0]       w_spawn_ev, w_kill_ev, w_hittable, w_hit, w_exit, w_pop;
  logic [3:0]       w_push, w_drop, w_wrong;
  logic [Y_W-1:0]   w_oldest_y [4];
  logic [2:0]       w_n_hit, w_n_miss;
  logic [16:0]      w_score_sum;
  logic [4:0]       w_miss_sum;
  logic [15:0]      w_score_nxt;
  logic [3:0]       w_misses_nxt;
  logic [CNT_W-1:0] w_rd_count;
  logic [PTR_W-1:0] w_rd_head;

  // Sum is formed one bit wider than y so the clamp sees the true value.
  function automatic logic [Y_W-1:0] advance(input logic [Y_W-1:0] y, input logic [3:0] spd);
    logic [Y_W:0] sum;
    sum = {1'b0, y} + (Y_W+1)'(spd);
    return (sum > L_SCREEN_H) ? L_SCREEN_H[Y_W-1:0] : sum[Y_W-1:0];
  endfunction

  always_comb begin
    w_active   = ~r_game_over;
    w_spawn_ev = bus.spawn & ~r_spawn_prev;
    w_kill_ev  = bus.kill & ~r_kill_prev;
    w_hittable = '0;
    w_hit      = '0;
    w_exit     = '0;
    w_pop      = '0;
    w_push     = '0;
    w_drop     = '0;
    w_wrong    = '0;
    w_n_hit    = '0;
    w_n_miss   = '0;
    for (int l = 0; l < 4; l++) begin
      w_oldest_y[l] = r_buf[l][r_head[l]];
      w_hittable[l] = (r_count[l] != '0) && (({1'b0, w_oldest_y[l]} + L_TILE_H) >= L_HIT_LO);
      w_hit[l]      = w_active & w_kill_ev[l] & w_hittable[l];
      w_exit[l]     = w_active & ~w_hit[l] & (r_count[l] != '0) &
                      ({1'b0, w_oldest_y[l]} == L_SCREEN_H);
      w_pop[l]      = w_hit[l] | w_exit[l];
`ifdef WRONG_PRESS_PENALTY_EN
      w_wrong[l]    = w_active & w_kill_ev[l] & ~w_hittable[l];
`endif
      // A pop in the same cycle frees the slot, so a full lane can still accept the spawn.
      w_push[l]     = w_active & w_spawn_ev[l] & ((r_count[l] != L_FULL) | w_pop[l]);
      w_drop[l]     = w_active & w_spawn_ev[l] & (r_count[l] == L_FULL) & ~w_pop[l];
      w_n_hit       = w_n_hit + 3'(w_hit[l]);
      w_n_miss      = w_n_miss + 3'(w_exit[l]) + 3'(w_wrong[l]);
    end
    w_score_sum  = {1'b0, r_score} + 17'(w_n_hit);
    w_score_nxt  = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    w_miss_sum   = {1'b0, r_misses} + 5'(w_n_miss);
    w_misses_nxt = w_miss_sum[4] ? 4'hF : w_miss_sum[3:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int l = 0; l < 4; l++) begin
        r_head[l]  <= '0;
        r_count[l] <= '0;
        for (int i = 0; i < DEPTH; i++) r_buf[l][i] <= '0;
      end
      r_spawn_prev <= '0;
      r_kill_prev  <= '0;
      r_hit_pulse  <= '0;
      r_score      <= '0;
      r_misses     <= '0;
      r_game_over  <= 1'b0;
      r_overflow   <= 1'b0;
    end else if (bus.screen) begin
      for (int l = 0; l < 4; l++) begin
        r_head[l]  <= '0;
        r_count[l] <= '0;
        for (int i = 0; i < DEPTH; i++) r_buf[l][i] <= '0;
      end
      r_spawn_prev <= '0;
      r_kill_prev  <= '0;
      r_hit_pulse  <= '0;
      r_score      <= '0;
      r_misses     <= '0;
      r_game_over  <= 1'b0;
      r_overflow   <= 1'b0;
    end else begin
      r_spawn_prev <= bus.spawn;
      r_kill_prev  <= bus.kill;
      r_hit_pulse  <= w_hit;
      if (w_active) begin
        r_score  <= w_score_nxt;
        r_misses <= w_misses_nxt;
        if (w_misses_nxt >= L_MAX_MISS) r_game_over <= 1'b1;
        if (|w_drop) r_overflow <= 1'b1;
      end
      for (int l = 0; l < 4; l++) begin
        if (w_active && bus.frame_tick) begin
          for (int i = 0; i < DEPTH; i++) r_buf[l][i] <= advance(r_buf[l][i], bus.speed);
        end
        // New tile lands at the tail; this write overrides the tick above for that slot.
        if (w_push[l]) r_buf[l][r_head[l] + r_count[l][PTR_W-1:0]] <= '0;
        r_head[l]  <= r_head[l] + PTR_W'(w_pop[l]);
        r_count[l] <= r_count[l] + CNT_W'(w_push[l]) - CNT_W'(w_pop[l]);
      end
    end
  end

  assign w_rd_count    = r_count[bus.rd_lane];
  assign w_rd_head     = r_head[bus.rd_lane];
  assign bus.rd_valid  = ({1'b0, bus.rd_idx} < w_rd_count);
  assign bus.rd_y      = bus.rd_valid ? r_buf[bus.rd_lane][w_rd_head + bus.rd_idx] : '0;
  assign bus.score     = r_score;
  assign bus.misses    = r_misses;
  assign bus.hit_pulse = r_hit_pulse;
  assign bus.game_over = r_game_over;
  assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_tile_lane_tracker.sv
// Bench for tile_lane_tracker: directed scenarios plus randomized play against a queue-based game model.
module tb_tile_lane_tracker;
  localparam int DEPTH    = 4;
  localparam int Y_W      = 10;
  localparam int SCREEN_H = 480;
  localparam int TILE_H   = 120;
  localparam int HIT_LO   = 360;
  localparam int MAX_MISS = 3;
`ifdef WRONG_PRESS_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic Clk;
  logic Reset;
  int   n_tests;
  int   n_fail;

  tile_lane_tracker_if #(.DEPTH(DEPTH), .Y_W(Y_W)) bus ();

  tile_lane_tracker #(
    .DEPTH(DEPTH), .Y_W(Y_W), .SCREEN_H(SCREEN_H), .TILE_H(TILE_H),
    .HIT_LO(HIT_LO), .MAX_MISS(MAX_MISS)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial begin
    Clk = 1'b0;
    forever #50 Clk = ~Clk;
  end

  // ---------------- reference model ----------------
  int         m_q[4][$];
  int         m_score;
  int         m_misses;
  logic [3:0] m_hit;
  logic       m_go;
  logic       m_ovf;
  logic [3:0] m_sp_prev;
  logic [3:0] m_kl_prev;

  task automatic model_clear();
    for (int l = 0; l < 4; l++) m_q[l].delete();
    m_score = 0; m_misses = 0; m_hit = '0; m_go = 1'b0; m_ovf = 1'b0;
    m_sp_prev = '0; m_kl_prev = '0;
  endtask

  task automatic model_step();
    logic [3:0] sev, kev;
    int nh, nm, ny;
    bit popped;
    if (bus.screen) begin
      model_clear();
      return;
    end
    sev = bus.spawn & ~m_sp_prev;
    kev = bus.kill & ~m_kl_prev;
    m_sp_prev = bus.spawn;
    m_kl_prev = bus.kill;
    m_hit = '0;
    if (m_go) return;
    nh = 0; nm = 0;
    for (int l = 0; l < 4; l++) begin
      popped = 1'b0;
      if (kev[l]) begin
        if (m_q[l].size() > 0 && m_q[l][0] + TILE_H >= HIT_LO) begin
          void'(m_q[l].pop_front());
          nh++; m_hit[l] = 1'b1; popped = 1'b1;
        end else if (PENALTY) begin
          nm++;
        end
      end
      if (!popped && m_q[l].size() > 0 && m_q[l][0] == SCREEN_H) begin
        void'(m_q[l].pop_front());
        nm++;
      end
      if (bus.frame_tick) begin
        for (int i = 0; i < m_q[l].size(); i++) begin
          ny = m_q[l][i] + int'(bus.speed);
          m_q[l][i] = (ny > SCREEN_H) ? SCREEN_H : ny;
        end
      end
      if (sev[l]) begin
        if (m_q[l].size() < DEPTH) m_q[l].push_back(0);
        else m_ovf = 1'b1;
      end
    end
    m_score  = (m_score + nh > 65535) ? 65535 : m_score + nh;
    m_misses = (m_misses + nm > 15) ? 15 : m_misses + nm;
    if (m_misses >= MAX_MISS) m_go = 1'b1;
  endtask

  function automatic int exp_rd_y(int l, int i);
    if (i < m_q[l].size()) return m_q[l][i];
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    model_step();
    @(posedge Clk);
    #5;
  endtask

  task automatic rise_spawn(int l);
    bus.spawn[l] = 1'b1;
    step();
    bus.spawn[l] = 1'b0;
    step();
  endtask

  task automatic ticks(int n);
    bus.frame_tick = 1'b1;
    repeat (n) step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic clear_game();
    bus.spawn = '0; bus.kill = '0; bus.frame_tick = 1'b0;
    bus.screen = 1'b1;
    step();
    bus.screen = 1'b0;
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_tests++;
    if (bus.score !== 16'd0 || bus.misses !== 4'd0 || bus.hit_pulse !== 4'd0 ||
        bus.game_over !== 1'b0 || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got score=%0d misses=%0d hit=%b go=%b ovf=%b required all 0",
               bus.score, bus.misses, bus.hit_pulse, bus.game_over, bus.overflow);
    end
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < DEPTH; i++) begin
        bus.rd_lane = 2'(l); bus.rd_idx = 2'(i); #1;
        n_tests++;
        if (bus.rd_valid !== 1'b0 || bus.rd_y !== '0) begin
          n_fail++;
          $display("FAIL reset_rd l%0d i%0d: got valid=%b y=%0d required 0/0", l, i, bus.rd_valid, bus.rd_y);
        end
      end
    end
  endtask

  task automatic test_hit();
    clear_game();
    bus.speed = 4'd8;
    rise_spawn(0);
    ticks(45);
    bus.rd_lane = 2'd0; bus.rd_idx = '0; #1;
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_y !== 10'(exp_rd_y(0, 0)) || exp_rd_y(0, 0) != 360) begin
      n_fail++;
      $display("FAIL hit_pre_y: got valid=%b y=%0d required 1/360 (model %0d)", bus.rd_valid, bus.rd_y, exp_rd_y(0, 0));
    end
    bus.kill[0] = 1'b1;
    step();
    n_tests++;
    if (bus.hit_pulse !== 4'b0001 || bus.score !== 16'd1 || bus.score !== 16'(m_score)) begin
      n_fail++;
      $display("FAIL hit_score: got hit=%b score=%0d required 0001/1", bus.hit_pulse, bus.score);
    end
    bus.kill[0] = 1'b0;
    step();
    n_tests++;
    if (bus.hit_pulse !== 4'b0000 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_after: got hit=%b valid=%b required 0000/0", bus.hit_pulse, bus.rd_valid);
    end
  endtask

  task automatic test_miss_game_over();
    clear_game();
    bus.speed = 4'd15;
    bus.rd_lane = 2'd2; bus.rd_idx = '0;
    for (int k = 1; k <= 2; k++) begin
      rise_spawn(2);
      ticks(32);
      n_tests++;
      if (bus.rd_y !== 10'd480 || bus.misses !== 4'(k - 1)) begin
        n_fail++;
        $display("FAIL miss_reach_%0d: got y=%0d misses=%0d required 480/%0d", k, bus.rd_y, bus.misses, k - 1);
      end
      step();
      n_tests++;
      if (bus.misses !== 4'(k) || bus.misses !== 4'(m_misses) || bus.rd_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL miss_count_%0d: got misses=%0d valid=%b required %0d/0", k, bus.misses, bus.rd_valid, k);
      end
    end
    rise_spawn(2);
    ticks(16);
    rise_spawn(2);
    ticks(16);
    step();
    n_tests++;
    if (bus.misses !== 4'd3 || bus.game_over !== 1'b1 || bus.game_over !== m_go) begin
      n_fail++;
      $display("FAIL game_over_set: got misses=%0d go=%b required 3/1", bus.misses, bus.game_over);
    end
    bus.spawn[0] = 1'b1;
    ticks(5);
    bus.spawn[0] = 1'b0;
    #1;
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_y !== 10'd240 || bus.rd_y !== 10'(exp_rd_y(2, 0))) begin
      n_fail++;
      $display("FAIL game_over_frozen: got valid=%b y=%0d required 1/240", bus.rd_valid, bus.rd_y);
    end
  endtask

  task automatic test_overflow();
    clear_game();
    repeat (5) rise_spawn(1);
    n_tests++;
    if (bus.overflow !== 1'b1 || bus.overflow !== m_ovf) begin
      n_fail++;
      $display("FAIL overflow_flag: got %b required 1", bus.overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_lane = 2'd1; bus.rd_idx = 2'(i); #1;
      n_tests++;
      if (bus.rd_valid !== 1'b1 || bus.rd_y !== 10'd0) begin
        n_fail++;
        $display("FAIL overflow_slot%0d: got valid=%b y=%0d required 1/0", i, bus.rd_valid, bus.rd_y);
      end
    end
  endtask

  task automatic test_tick_and_hit();
    clear_game();
    bus.speed = 4'd10;
    rise_spawn(3);
    ticks(40);
    rise_spawn(3);
    bus.kill[3] = 1'b1; bus.frame_tick = 1'b1;
    step();
    bus.kill[3] = 1'b0; bus.frame_tick = 1'b0;
    n_tests++;
    if (bus.score !== 16'd1 || bus.hit_pulse !== 4'b1000) begin
      n_fail++;
      $display("FAIL tickhit_score: got score=%0d hit=%b required 1/1000", bus.score, bus.hit_pulse);
    end
    bus.rd_lane = 2'd3; bus.rd_idx = '0; #1;
    n_tests++;
    if (bus.rd_valid !== 1'b1 || bus.rd_y !== 10'd10 || bus.rd_y !== 10'(exp_rd_y(3, 0))) begin
      n_fail++;
      $display("FAIL tickhit_next: got valid=%b y=%0d required 1/10", bus.rd_valid, bus.rd_y);
    end
    bus.rd_idx = 2'd1; #1;
    n_tests++;
    if (bus.rd_valid !== 1'b0 || bus.rd_y !== 10'd0) begin
      n_fail++;
      $display("FAIL tickhit_idx1: got valid=%b y=%0d required 0/0", bus.rd_valid, bus.rd_y);
    end
  endtask

  task automatic test_wrong_press();
    clear_game();
    bus.kill[1] = 1'b1;
    step();
    bus.kill[1] = 1'b0;
    step();
    n_tests++;
    if (bus.misses !== 4'(PENALTY) || bus.misses !== 4'(m_misses)) begin
      n_fail++;
      $display("FAIL wrong_press: got misses=%0d required %0d", bus.misses, PENALTY);
    end
    rise_spawn(0);
    bus.screen = 1'b1;
    step();
    bus.screen = 1'b0;
    bus.rd_lane = 2'd0; bus.rd_idx = '0; #1;
    n_tests++;
    if (bus.misses !== 4'd0 || bus.score !== 16'd0 || bus.game_over !== 1'b0 ||
        bus.overflow !== 1'b0 || bus.rd_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL screen_clear: got misses=%0d score=%0d go=%b ovf=%b valid=%b required all 0",
               bus.misses, bus.score, bus.game_over, bus.overflow, bus.rd_valid);
    end
  endtask

  task automatic test_random();
    clear_game();
    bus.speed = 4'd12;
    for (int c = 0; c < 1500; c++) begin
      bus.spawn      = bus.spawn ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.kill       = bus.kill ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
      bus.frame_tick = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 31) == 0) bus.speed = 4'($urandom_range(0, 15));
      bus.screen     = (m_go && $urandom_range(0, 7) == 0) || ($urandom_range(0, 299) == 0);
      bus.rd_lane    = 2'($urandom_range(0, 3));
      bus.rd_idx     = 2'($urandom_range(0, DEPTH - 1));
      step();
      n_tests++;
      if (bus.score !== 16'(m_score) || bus.misses !== 4'(m_misses) || bus.hit_pulse !== m_hit ||
          bus.game_over !== m_go || bus.overflow !== m_ovf) begin
        n_fail++;
        $display("FAIL rand_state c%0d: got score=%0d misses=%0d hit=%b go=%b ovf=%b required %0d/%0d/%b/%b/%b",
                 c, bus.score, bus.misses, bus.hit_pulse, bus.game_over, bus.overflow,
                 m_score, m_misses, m_hit, m_go, m_ovf);
      end
      n_tests++;
      if (bus.rd_valid !== (int'(bus.rd_idx) < m_q[bus.rd_lane].size()) ||
          bus.rd_y !== 10'(exp_rd_y(int'(bus.rd_lane), int'(bus.rd_idx)))) begin
        n_fail++;
        $display("FAIL rand_rd c%0d l%0d i%0d: got valid=%b y=%0d required y=%0d",
                 c, bus.rd_lane, bus.rd_idx, bus.rd_valid, bus.rd_y,
                 exp_rd_y(int'(bus.rd_lane), int'(bus.rd_idx)));
      end
    end
    bus.screen = 1'b0;
  endtask

  task automatic test_async_reset();
    clear_game();
    bus.speed = 4'd15;
    repeat (5) begin
      rise_spawn(0);
      ticks(16);
      bus.kill[0] = 1'b1;
      step();
      bus.kill[0] = 1'b0;
      step();
    end
    rise_spawn(0);
    rise_spawn(0);
    bus.rd_lane = 2'd0; bus.rd_idx = 2'd1; #1;
    n_tests++;
    if (bus.score !== 16'd5 || bus.rd_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got score=%0d valid=%b required 5/1", bus.score, bus.rd_valid);
    end
    Reset = 1'b0;
    #2;
    model_clear();
    test_reset();
    #5;
    Reset = 1'b1;
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    n_tests = 0; n_fail = 0;
    Reset = 1'b0;
    bus.frame_tick = 1'b0; bus.spawn = '0; bus.kill = '0; bus.speed = '0;
    bus.screen = 1'b0; bus.rd_lane = '0; bus.rd_idx = '0;
    model_clear();
    repeat (3) @(posedge Clk);
    #5;
    Reset = 1'b1;
    test_reset();
    test_hit();
    test_miss_game_over();
    test_overflow();
    test_tick_and_hit();
    test_wrong_press();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/tile_lane_tracker.md
Name: tile_lane_tracker

Overview:
Sits directly downstream of the song sequencer FSM.
- Consumes its per-lane note-spawn strobes (block1..4), key-kill levels (kill1..4), speed and start-screen flag.
- Tracks every falling tile's vertical position per lane, advances the tiles once per video frame, and scores hits and misses.
- Exposes tile positions to the VGA renderer through a combinational read port.

Parameters:
DEPTH, 4, max live tiles per lane (power of 2)
Y_W, 10, width of tile y coordinate
SCREEN_H, 480, y at which a tile has fully left the playfield
TILE_H, 120, tile height in pixels
HIT_LO, 360, top of hit window; tile is hittable when y+TILE_H >= HIT_LO
MAX_MISS, 3, misses that end the game

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-low reset (0 = reset)
frame_tick  in  1  one-cycle pulse per frame, synchronous to Clk
spawn  in  4  lane spawn levels {block4..block1}; rising edge = new tile
kill  in  4  lane key levels {kill4..kill1}; rising edge = press
speed  in  4  pixels advanced per frame tick
screen  in  1  start-screen active; level 1 = synchronous game clear
rd_lane  in  2  renderer lane select
rd_idx  in  $clog2(DEPTH)  renderer slot, 0 = oldest tile
rd_valid  out  1  selected slot holds a live tile
rd_y  out  Y_W  y of selected tile (top edge)
score  out  16  hit count, saturating at 16'hFFFF
misses  out  4  miss count, saturating at 15
hit_pulse  out  4  one-cycle per-lane hit strobe
game_over  out  1  sticky, set when misses >= MAX_MISS
overflow  out  1  sticky, a spawn was dropped because a lane was full

Behaviour:
- Reset (async, Reset=0): all lanes empty; edge-detect registers = 0; score, misses, hit_pulse, game_over and overflow = 0. Same clear is applied synchronously while screen=1.
- Per lane: circular buffer of DEPTH y entries, head pointer (oldest) and count (0..DEPTH).
- Edge detect: registered previous spawn/kill. Event = cur & ~prev.
- Spawn event: if count<DEPTH, push y=0 at tail, count+1. If count==DEPTH, drop it and set overflow.
- frame_tick: every live y <= min(y+speed, SCREEN_H). speed=0 freezes motion.
- Press event, lane count>0 and oldest y+TILE_H >= HIT_LO:
  - pop oldest; score+1; hit_pulse[lane]=1 the next cycle.
  - Evaluated on the pre-tick y when frame_tick occurs in the same cycle; the tick still advances the remaining tiles.
- Exit: in a cycle with no press-pop in that lane, if the oldest live y == SCREEN_H, pop it and misses+1.
- At most one pop per lane per cycle.
- Same lane, spawn + pop in the same cycle: both take effect; count unchanged; allowed even when full.
- Multiple lanes with events in one cycle: score and misses increase by the number of lane events (0..4), then saturate.
- game_over set when misses >= MAX_MISS. While set, tick/spawn/press are ignored and state is frozen until screen=1 or Reset.
- Outputs score, misses, game_over and overflow are registered; they update one cycle after the causing event.
- hit_pulse is registered and lasts one cycle.
- rd_valid/rd_y are combinational:
  - rd_valid = rd_idx < count[rd_lane]
  - rd_y = buf[rd_lane][(head+rd_idx) mod DEPTH]
  - rd_y = 0 when not valid.
- Pointers wrap modulo DEPTH. y arithmetic is done at Y_W+1 bits before the clamp, so there is no wrap.

Optional Feature:
WRONG_PRESS_PENALTY_EN.
- Defined: a press event with an empty lane, or with the oldest tile outside the hit window, adds 1 to misses and pops nothing.
- Undefined: such presses are ignored.

Test Plan:
1. Reset low mid-game with score=5, lane0 count=2 -> all outputs 0 immediately (async); rd_valid=0 for every lane/idx.
2. Spawn lane0 with speed=8, then 45 frame_ticks (y=360) and a kill[0] rise -> y+120=480>=360 so it hits: score=1, hit_pulse=4'b0001 for one cycle, lane0 empty.
3. Spawn lane2 with speed=15, 32 ticks (y=480) and no press -> misses=1 one cycle after y reaches 480; 3 such misses -> game_over=1, further ticks leave rd_y unchanged.
4. Five spawn rises on lane1 with no ticks -> count=4, overflow=1; rd_idx 0..3 valid, all y=0.
5. Lane3 tile at y=400, with frame_tick and kill[3] rise in the same cycle, plus a second tile at y=0 -> first tile popped as a hit, second tile moves to y=speed and becomes rd_idx 0.
6. kill[1] rise on an empty lane -> misses=1 with WRONG_PRESS_PENALTY_EN, misses=0 without; then screen=1 for one cycle -> all counters 0.
